// File: rtl/sqrt_rr_sched.sv
// sqrt_rr_sched
//   Round-robin front end that shares one sequential square-root unit
//   (cordic_sqrt_seq) between N requesters. A request seen in IDLE is
//   granted in that same cycle. The operand is then handed to the unit with
//   a one-cycle start pulse, and the scheduler waits for the unit's busy to
//   fall. The result is returned tagged with the requester index. If busy
//   stays high for too long, a timeout is flagged.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   req[N]       per-requester request, held with operand until gnt
//   req_din      N packed 16-bit operands, requester i at [16i+15:16i]
//   gnt[N]       one-hot accept pulse (combinational, IDLE only)
//   rsp_valid    one-cycle result strobe
//   rsp_id       requester index owning rsp_data
//   rsp_data     result, held until the next rsp_valid
//   sq_start     start pulse to the sqrt unit
//   sq_din       operand to the sqrt unit, zero when sq_start is low
//   sq_busy      busy from the sqrt unit
//   sq_dout      result from the sqrt unit
//   timeout_err  one-cycle pulse when the unit stays busy for TMO cycles
//   idle         high in IDLE with no request pending
module sqrt_rr_sched #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int TMO = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [16*N-1:0] req_din,
  output logic [N-1:0]    gnt,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [15:0]     rsp_data,
  output logic            sq_start,
  output logic [15:0]     sq_din,
  input  logic            sq_busy,
  input  logic [15:0]     sq_dout,
  output logic            timeout_err,
  output logic            idle
);

  localparam int CW = $clog2(TMO) + 1;
  localparam int SW = IDW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] r_sel;
  logic [15:0]    r_opnd;
  logic [CW-1:0]  r_cnt;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [15:0]    r_rsp_data;

  logic           w_found;
  logic [IDW-1:0] w_pick;
  logic [SW-1:0]  w_sum;
  logic [IDW-1:0] w_idx;
  logic           w_tmo_hit;

  // Search order is last+1, last+2, ... wrapping at N, so the requester
  // served most recently has the lowest priority on the next pick.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, r_last} + SW'(k);
      if (w_sum >= SW'(N)) w_sum = w_sum - SW'(N);
      w_idx = w_sum[IDW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_tmo_hit = (r_cnt == CW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= IDW'(N - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sel   <= w_pick;
            r_opnd  <= req_din[16*w_pick +: 16];
            r_last  <= w_pick;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_ARM;
        // The unit's busy is not meaningful until the cycle after start,
        // so this cycle only clears the watchdog.
        S_ARM: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (!sq_busy)       r_state <= S_DONE;
          else if (w_tmo_hit) r_state <= S_IDLE;
        end
        S_DONE: begin
          r_rsp_data  <= sq_dout;
          r_rsp_id    <= r_sel;
          r_rsp_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pulses decoded from state are masked during reset so an aborted job
  // never emits a grant, start or timeout while rst is high.
  always_comb begin
    gnt = '0;
    if (!rst && r_state == S_IDLE && w_found) gnt[w_pick] = 1'b1;
  end

  assign sq_start    = !rst && (r_state == S_ISSUE);
  assign sq_din      = sq_start ? r_opnd : 16'h0000;
  assign timeout_err = !rst && (r_state == S_WAIT) && sq_busy && w_tmo_hit;
  assign idle        = (r_state == S_IDLE) && (req == '0);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;

endmodule
